// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed common-anode 7-segment scanner with frame-synchronous double buffering
module seg7_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  suppress_zeros,
    output logic [6:0]            segments,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     digit_n,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [1:0]          state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic                frame_end;
    logic                commit;

    logic [4*DIGITS-1:0] shadow_val, disp_val;
    logic [DIGITS-1:0]   shadow_dp, disp_dp;
    logic                pending;

    logic [3:0]          nibble;
    logic                upper_zero;
    logic                blank_digit;
    logic [DIGITS-1:0]   one_hot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        frame_end = 1'b0;
        if (!enable) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                S_BLANK: begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == BLANK_LAST) state_nx = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = S_BLANK;
                        cnt_nx   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nx    = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Frame start: entering BLANK for digit 0, from IDLE or from the last SHOW.
    assign commit = (state_nx == S_BLANK) && (state != S_BLANK) && (idx_nx == '0) && pending;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // A load coinciding with a commit refills the shadow, so pending must stay set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
                pending    <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        one_hot    = '0;
        one_hot[idx] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && disp_val[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
    end

    assign nibble      = disp_val[4*idx +: 4];
    assign blank_digit = suppress_zeros && (idx != '0) && upper_zero && !disp_dp[idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segments   <= 7'h7F;
            dp_n       <= 1'b1;
            digit_n    <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (enable && state == S_SHOW) begin
                digit_n  <= ~one_hot;
                segments <= blank_digit ? 7'h7F : hex_to_seg(nibble);
                dp_n     <= blank_digit ? 1'b1 : ~disp_dp[idx];
            end else begin
                digit_n  <= '1;
                segments <= 7'h7F;
                dp_n     <= 1'b1;
            end
        end
    end

endmodule
